mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory between the multicycle CPU controller/datapath and a DMA/debug loader port. It accepts one request at a time, drives the memory strobes for a fixed number of wait states, and returns read data with a one-cycle `ready` pulse. The CPU controller stalls its FSM on `cpu_ready`. The block sits between the datapath's memory address/data muxes and the memory array.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LAT`, 2, memory access cycles per transfer (≥1)
- `FAIR_MAX`, 4, consecutive CPU grants tolerated while DMA is waiting (used only with `MEM_ARB_FAIR_EN`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  CPU write (1) / read (0)
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_ready`  out  1  CPU transfer complete, 1-cycle pulse
- `dma_req`  in  1  DMA request
- `dma_we`  in  1  DMA write / read
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_ready`  out  1  DMA transfer complete, 1-cycle pulse
- `rdata`  out  DATA_W  captured read data, shared by both requesters
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: latch the grant (`CPU`/`DMA`), go to ACCESS, load the wait counter with `LAT-1`.
  - Both requesting: CPU wins. With `MEM_ARB_FAIR_EN`, DMA wins when the starvation count equals `FAIR_MAX`.
- **ACCESS**
  - `mem_rd = ~we_g` and `mem_wr = we_g`, where `we_g` is the granted requester's `we`.
  - `mem_addr` and `mem_wdata` are muxed from the granted requester.
  - The counter decrements each cycle. When it reaches 0: capture `mem_rdata` into `rdata` (reads only) and go to RESP.
- **RESP**
  - The granted requester's `ready` is high for exactly one cycle. Then go to IDLE.
  - `rdata` holds its value until the next read capture. Writes leave `rdata` unchanged.
- Requester rules:
  - `req`, `we`, `addr` and `wdata` are held stable from assertion until `ready`.
  - `req` is dropped or re-presented the cycle after `ready`.
  - A request change during ACCESS for the granted requester is a protocol violation and is not checked.
  - The non-granted requester waits. It gets no `ready` and loses no request.
- Memory outputs are driven only in ACCESS. Outside ACCESS: strobes low, `mem_addr`/`mem_wdata` = 0.
- The counter is `$clog2(LAT+1)` bits. With `LAT=1` the block goes ACCESS→RESP after one cycle.

## Timing
- Reset values: state IDLE, all strobes 0, `cpu_ready`/`dma_ready` 0, `rdata` 0, `mem_addr`/`mem_wdata` 0, `busy` 0, starvation count 0, counter 0.
- Request sampled in IDLE at edge k:
  - Strobes high for cycles k+1 .. k+LAT.
  - `rdata` valid and `ready` high in cycle k+LAT+1.
  - Earliest next grant at edge k+LAT+2.
  - Total `LAT+2` cycles per transfer.
- Back-to-back requests from one requester incur one IDLE cycle between transfers.
- `rst` mid-transfer: strobes drop asynchronously, no `ready` is issued, and the requester must re-request.
- No combinational path from any `req` to the `mem_*` outputs. Grant is decided in IDLE and registered.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - The starvation counter increments on each CPU grant made while `dma_req` is high.
  - At `FAIR_MAX` the next contested arbitration goes to DMA.
  - Any DMA grant clears the counter. The counter saturates at `FAIR_MAX`.
- Not defined: strict CPU priority. DMA can starve indefinitely, and `FAIR_MAX` is unused.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (`IDLE`, `ACCESS`, `RESP`).
  - Grant encoding (`GNT_CPU = 1'b0`, `GNT_DMA = 1'b1`).
- Sub-module `mem_arb_fair`: the starvation counter plus the DMA-override decision. Instantiated only under `MEM_ARB_FAIR_EN`. Without the macro, override is tied 0.

## Test plan
1. CPU read, `LAT=2`, addr `0x10`, memory returns `0xDEADBEEF` → `mem_rd` high 2 cycles, `cpu_ready` pulse at cycle 3 after grant, `rdata=0xDEADBEEF`, `dma_ready` stays 0.
2. DMA write addr `0x40`, data `0x12345678` → `mem_wr` high 2 cycles with that addr/data, one `dma_ready` pulse, `rdata` unchanged.
3. Simultaneous `cpu_req` and `dma_req` in IDLE, fairness off → CPU served first; DMA served in the very next transfer after CPU drops `req`.
4. Fairness on, `FAIR_MAX=4`, CPU requests continuously while DMA holds `req` → grant order is 4 CPU, 1 DMA, 4 CPU, …
5. Assert `rst` during the 2nd ACCESS cycle of a CPU write → `mem_wr` low immediately, no `cpu_ready`, state IDLE after reset release; CPU re-request completes normally.
6. `LAT=1` instance, CPU read → `cpu_ready` one cycle after the single strobe cycle, 3 cycles total per transfer.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state and grant encodings for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } arb_gnt_t;

endpackage

// File: rtl/mem_arb_fair.sv
// rtl/mem_arb_fair.sv - DMA starvation counter; forces a DMA grant after FAIR_MAX contested CPU wins
module mem_arb_fair
  import mem_arb_pkg::*;
#(
  parameter int FAIR_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_valid,
  input  logic cpu_req,
  input  logic dma_req,
  output logic dma_override
);

  localparam int SW = $clog2(FAIR_MAX + 1);

  logic [SW-1:0] starve;
  arb_gnt_t      gnt_now;

  assign dma_override = (starve == SW'(FAIR_MAX));
  assign gnt_now      = (dma_req && (!cpu_req || dma_override)) ? GNT_DMA : GNT_CPU;

  // Only CPU wins taken while DMA was waiting count as starvation; saturates at FAIR_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (arb_valid) begin
      if (gnt_now == GNT_DMA) begin
        starve <= '0;
      end else if (dma_req && !dma_override) begin
        starve <= starve + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter for the unified memory, fixed LAT wait states
// Optional fairness: define MEM_ARB_FAIR_EN to enable DMA anti-starvation via mem_arb_fair.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LAT      = 2,
  parameter int FAIR_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 1);

  arb_state_t        state, state_n;
  arb_gnt_t          gnt, gnt_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              any_req;
  logic              dma_win;
  logic              dma_override;
  logic              we_g;
  logic [ADDR_W-1:0] addr_g;
  logic [DATA_W-1:0] wdata_g;
  logic              last_access;

  assign any_req = cpu_req | dma_req;
  assign dma_win = dma_req & (~cpu_req | dma_override);

`ifdef MEM_ARB_FAIR_EN
  mem_arb_fair #(
    .FAIR_MAX (FAIR_MAX)
  ) u_fair (
    .clk          (clk),
    .rst          (rst),
    .arb_valid    ((state == IDLE) && any_req),
    .cpu_req      (cpu_req),
    .dma_req      (dma_req),
    .dma_override (dma_override)
  );
`else
  logic unused_fair;
  assign dma_override = 1'b0;
  assign unused_fair  = ^FAIR_MAX;
`endif

  assign we_g        = (gnt == GNT_DMA) ? dma_we    : cpu_we;
  assign addr_g      = (gnt == GNT_DMA) ? dma_addr  : cpu_addr;
  assign wdata_g     = (gnt == GNT_DMA) ? dma_wdata : cpu_wdata;
  assign last_access = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= GNT_CPU;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = ACCESS;
          gnt_n   = dma_win ? GNT_DMA : GNT_CPU;
          cnt_n   = CW'(LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory side is decoded from registered state only, so reset drops the strobes at once.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_rd    = ~we_g;
      mem_wr    = we_g;
      mem_addr  = addr_g;
      mem_wdata = wdata_g;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (last_access && !we_g) begin
      rdata <= mem_rdata;
    end
  end

  assign cpu_ready = (state == RESP) && (gnt == GNT_CPU);
  assign dma_ready = (state == RESP) && (gnt == GNT_DMA);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter: LAT=2 and LAT=1 instances vs a transfer-timeline model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int FMAX = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A0000;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req [2], cpu_we [2], dma_req [2], dma_we [2];
  logic [AW-1:0] cpu_addr [2], dma_addr [2], mem_addr [2];
  logic [DW-1:0] cpu_wdata [2], dma_wdata [2], mem_wdata [2], mem_rdata [2], rdata [2];
  logic          cpu_ready [2], dma_ready [2], mem_rd [2], mem_wr [2], busy [2];

  assign mem_rdata[0] = memf(mem_addr[0]);
  assign mem_rdata[1] = memf(mem_addr[1]);

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(2), .FAIR_MAX(FMAX)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ready(cpu_ready[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
    .dma_ready(dma_ready[0]), .rdata(rdata[0]),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1), .FAIR_MAX(FMAX)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ready(cpu_ready[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
    .dma_ready(dma_ready[1]), .rdata(rdata[1]),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Model: each transfer is a record stamped with the edge number that granted it.
  int            cyc = 0;
  bit            m_act [2], m_dma [2], m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2], m_rdata [2];
  int            m_g [2], m_starve [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 1'b0; m_starve[d] = 0; m_rdata[d] = '0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int L;
        bit dw;
        L = lat_of(d);
        if (m_act[d]) begin
          if (cyc == m_g[d] + L && !m_we[d]) m_rdata[d] = memf(m_addr[d]);
          if (cyc == m_g[d] + L + 1) m_act[d] = 1'b0;
        end else if (cpu_req[d] || dma_req[d]) begin
          dw = dma_req[d] && (!cpu_req[d] || (FAIR && m_starve[d] == FMAX));
          if (dw) m_starve[d] = 0;
          else if (dma_req[d] && m_starve[d] < FMAX) m_starve[d]++;
          m_act[d]   = 1'b1;
          m_dma[d]   = dw;
          m_g[d]     = cyc;
          m_we[d]    = dw ? dma_we[d]    : cpu_we[d];
          m_addr[d]  = dw ? dma_addr[d]  : cpu_addr[d];
          m_wdata[d] = dw ? dma_wdata[d] : cpu_wdata[d];
        end
      end
    end
  end

  // Strobe windows: edges g .. g+LAT-1 are access cycles, edge g+LAT opens the ready cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit acc, rsp;
      acc = m_act[d] && (cyc < m_g[d] + lat_of(d));
      rsp = m_act[d] && (cyc == m_g[d] + lat_of(d));
      chk("mem_rd",    d, 32'(mem_rd[d]),    32'(acc && !m_we[d]));
      chk("mem_wr",    d, 32'(mem_wr[d]),    32'(acc && m_we[d]));
      chk("mem_addr",  d, mem_addr[d],       acc ? m_addr[d]  : 32'h0);
      chk("mem_wdata", d, mem_wdata[d],      acc ? m_wdata[d] : 32'h0);
      chk("cpu_ready", d, 32'(cpu_ready[d]), 32'(rsp && !m_dma[d]));
      chk("dma_ready", d, 32'(dma_ready[d]), 32'(rsp && m_dma[d]));
      chk("busy",      d, 32'(busy[d]),      32'(acc || rsp));
      chk("rdata",     d, rdata[d],          m_rdata[d]);
    end
  end

  int rd_cnt [2] = '{0, 0};
  int wr_cnt [2] = '{0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_rd[d] === 1'b1) rd_cnt[d]++;
      if (mem_wr[d] === 1'b1) wr_cnt[d]++;
    end
  end

  // Presents a request (held until ready) and returns the number of falling edges until ready.
  task automatic xfer(input int d, input bit dma, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, output int n);
    if (dma) begin
      dma_req[d] = 1'b1; dma_we[d] = we; dma_addr[d] = a; dma_wdata[d] = wd;
    end else begin
      cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = wd;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dma ? dma_ready[d] : cpu_ready[d]) && n < 100);
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout dut%0d: no ready after %0d cycles, expected one", d, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int    n, n2, rb, wb;
  string ord;
  string ord_exp;

  initial begin
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 0; cpu_we[d] = 0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      dma_req[d] = 0; dma_we[d] = 0; dma_addr[d] = '0; dma_wdata[d] = '0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy",  d, 32'(busy[d]),   32'h0);
      chk("reset_rd",    d, 32'(mem_rd[d]), 32'h0);
      chk("reset_wr",    d, 32'(mem_wr[d]), 32'h0);
      chk("reset_rdata", d, rdata[d],       32'h0);
      chk("reset_addr",  d, mem_addr[d],    32'h0);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: CPU read, LAT=2
    rb = rd_cnt[0];
    xfer(0, 1'b0, 1'b0, 32'h10, 32'h0, n);
    cpu_req[0] = 1'b0;
    chk("t1_latency",   0, n, 3);
    chk("t1_rdata",     0, rdata[0], 32'hDEADBEEF);
    chk("t1_rd_cycles", 0, rd_cnt[0] - rb, 2);
    @(negedge clk);

    // 2: DMA write
    rb = rd_cnt[0]; wb = wr_cnt[0];
    xfer(0, 1'b1, 1'b1, 32'h40, 32'h12345678, n);
    dma_req[0] = 1'b0;
    chk("t2_latency",   0, n, 3);
    chk("t2_wr_cycles", 0, wr_cnt[0] - wb, 2);
    chk("t2_rd_cycles", 0, rd_cnt[0] - rb, 0);
    chk("t2_rdata",     0, rdata[0], 32'hDEADBEEF);
    @(negedge clk);

    // 3: simultaneous requests, CPU first then DMA right after
    fork
      begin xfer(0, 1'b0, 1'b0, 32'h20, 32'h0, n);  cpu_req[0] = 1'b0; end
      begin xfer(0, 1'b1, 1'b0, 32'h30, 32'h0, n2); dma_req[0] = 1'b0; end
    join
    chk("t3_cpu_latency", 0, n, 3);
    chk("t3_dma_latency", 0, n2, 7);
    chk("t3_rdata",       0, rdata[0], memf(32'h30));
    @(negedge clk);

    // 4: CPU back-to-back while DMA waits
    ord = "";
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          xfer(0, 1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, n);
          ord = {ord, "C"};
        end
        cpu_req[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 2; i++) begin
          xfer(0, 1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), n2);
          ord = {ord, "D"};
        end
        dma_req[0] = 1'b0;
      end
    join
    ord_exp = FAIR ? "CCCCDCCCCD" : "CCCCCCCCDD";
    n_cmp++;
    if (ord != ord_exp) begin
      n_bad++;
      $display("FAIL t4_grant_order dut0: got %s, expected %s", ord, ord_exp);
    end
    @(negedge clk);

    // 5: reset during the second access cycle of a CPU write
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h80; cpu_wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("t5_wr_before_rst", 0, 32'(mem_wr[0]), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t5_wr_async_drop", 0, 32'(mem_wr[0]),    32'h0);
    chk("t5_busy_in_rst",   0, 32'(busy[0]),      32'h0);
    chk("t5_no_ready",      0, 32'(cpu_ready[0]), 32'h0);
    cpu_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_after", 0, 32'(busy[0]), 32'h0);
    wb = wr_cnt[0];
    xfer(0, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, n);
    cpu_req[0] = 1'b0;
    chk("t5_rereq_latency", 0, n, 3);
    chk("t5_rereq_wr",      0, wr_cnt[0] - wb, 2);
    @(negedge clk);

    // 6: LAT=1 instance, single read then a back-to-back read
    rb = rd_cnt[1];
    xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, n);
    chk("t6_latency",   1, n, 2);
    chk("t6_rdata",     1, rdata[1], 32'hDEADBEEF);
    chk("t6_rd_cycles", 1, rd_cnt[1] - rb, 1);
    xfer(1, 1'b0, 1'b0, 32'h44, 32'h0, n);
    cpu_req[1] = 1'b0;
    chk("t6_period", 1, n, 3);
    chk("t6_rdata2", 1, rdata[1], memf(32'h44));
    @(negedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
